// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit master: command codes, FSM states,
// bus phases and the per-phase open-drain line decode.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_WRITE,
    ST_READ
  } state_e;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_A = 2'd0;
  localparam phase_t PH_B = 2'd1;
  localparam phase_t PH_C = 2'd2;
  localparam phase_t PH_D = 2'd3;

  // 1 = pull the line low.
  typedef struct packed {
    logic scl;
    logic sda;
  } oe_t;

  // rep: START entered with the bus already owned, so SCL stays low in phase A.
  function automatic oe_t phase_oe(state_e st, phase_t ph, logic rep, logic wbit);
    oe_t oe;
    oe = '0;
    case (st)
      ST_START: begin
        oe.scl = (ph == PH_A) ? rep : (ph == PH_D);
        oe.sda = (ph == PH_C) || (ph == PH_D);
      end
      ST_STOP: begin
        oe.scl = (ph == PH_A);
        oe.sda = (ph == PH_A) || (ph == PH_B);
      end
      ST_WRITE: begin
        oe.scl = (ph == PH_A) || (ph == PH_D);
        oe.sda = ~wbit;
      end
      ST_READ: begin
        oe.scl = (ph == PH_A) || (ph == PH_D);
        oe.sda = 1'b0;
      end
      default: oe = '0;
    endcase
    return oe;
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchronizer for an asynchronous bus line; resets to the
// released (high) level so an idle bus never looks driven.
module i2c_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_bit_master.sv
// I2C master bit engine: START / STOP / WRITE / READ, four timed phases each.
// Optional macro I2C_CLK_STRETCH_EN honours slave clock stretching in phase B.
module i2c_bit_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       cmd_wbit,
  output logic       rsp_valid,
  output logic       rsp_rbit,
  output logic       rsp_err,
  output logic       arb_lost,
  output logic       bus_owned,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

  logic scl_s, sda_s;

  i2c_sync2 u_scl_sync (.clk(clk), .rst_n(rst_n), .d(scl_in), .q(scl_s));
  i2c_sync2 u_sda_sync (.clk(clk), .rst_n(rst_n), .d(sda_in), .q(sda_s));

  state_e           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             rep_q, rep_d, wbit_q, wbit_d, rbit_q, rbit_d;
  logic             err_q, err_d, owned_q, owned_d, lost_q, lost_d;
  oe_t              oe_q, oe_d;

  logic busy, div_hold, phase_end, arb_loss, normal_done, done, accept;

  assign busy = (state_q != ST_IDLE);

`ifdef I2C_CLK_STRETCH_EN
  assign div_hold = busy && (phase_q == PH_B) && !scl_s;
`else
  logic scl_unused;
  assign scl_unused = scl_s;
  assign div_hold   = 1'b0;
`endif

  assign phase_end = busy && (div_q == '0) && !div_hold;

  // Another master pulled SDA low where we expect it released.
  assign arb_loss = !sda_s &&
                    (((state_q == ST_START) && (phase_q == PH_B)) ||
                     ((state_q == ST_WRITE) && (phase_q == PH_C) && wbit_q));

  assign normal_done = phase_end && (phase_q == PH_D) && !arb_loss;
  assign done        = normal_done || arb_loss;
  assign cmd_ready   = !busy || done;
  assign accept      = cmd_valid && cmd_ready;

  always_comb begin
    logic owned_base;
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    phase_d = phase_q;
    div_d   = div_q;
    rep_d   = rep_q;
    wbit_d  = wbit_q;
    rbit_d  = rbit_q;
    err_d   = 1'b0;
    lost_d  = lost_q | arb_loss;

    owned_base = owned_q;
    if (arb_loss || (normal_done && (state_q == ST_STOP))) owned_base = 1'b0;
    owned_d = owned_base;

    if (busy) begin
      if (div_hold) begin
        div_d = RELOAD;
      end else if (phase_end) begin
        phase_d = phase_q + 2'd1;
        div_d   = RELOAD;
      end else begin
        div_d = div_q - DIV_W'(1);
      end
    end

    if ((state_q == ST_READ) && (phase_q == PH_C) && phase_end) rbit_d = sda_s;

    if (done) begin
      state_d = ST_IDLE;
      phase_d = PH_A;
      div_d   = RELOAD;
    end

    // A new command may start in the same cycle the previous one completes.
    if (accept) begin
      phase_d = PH_A;
      div_d   = RELOAD;
      wbit_d  = cmd_wbit;
      case (cmd_e'(cmd))
        CMD_START: begin
          state_d = ST_START;
          rep_d   = owned_base;
          owned_d = 1'b1;
          lost_d  = 1'b0;
        end
        CMD_STOP:  if (owned_base) state_d = ST_STOP;  else err_d = 1'b1;
        CMD_WRITE: if (owned_base) state_d = ST_WRITE; else err_d = 1'b1;
        CMD_READ:  if (owned_base) state_d = ST_READ;  else err_d = 1'b1;
        default:   err_d = 1'b1;
      endcase
    end

    oe_d = phase_oe(state_d, phase_d, rep_d, wbit_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= PH_A;
      div_q   <= RELOAD;
      rep_q   <= 1'b0;
      wbit_q  <= 1'b0;
      rbit_q  <= 1'b0;
      err_q   <= 1'b0;
      owned_q <= 1'b0;
      lost_q  <= 1'b0;
      oe_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      rep_q   <= rep_d;
      wbit_q  <= wbit_d;
      rbit_q  <= rbit_d;
      err_q   <= err_d;
      owned_q <= owned_d;
      lost_q  <= lost_d;
      oe_q    <= oe_d;
    end
  end

  assign scl_oe    = oe_q.scl;
  assign sda_oe    = oe_q.sda;
  assign bus_owned = owned_q;
  assign arb_lost  = lost_q;
  assign rsp_valid = done || err_q;
  assign rsp_err   = arb_loss || err_q;
  assign rsp_rbit  = normal_done && (state_q == ST_READ) && rbit_q;

endmodule

// File: tb/tb_i2c_bit_master.sv
// Directed bench for i2c_bit_master with CLK_DIV = 4 and a pulled-up bus model;
// the bench can pull either line low to emulate a slave or a competing master.
module tb_i2c_bit_master;
  import i2c_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int LAT     = 4 * CLK_DIV - 1;  // cycle index of rsp_valid after acceptance
`ifdef I2C_CLK_STRETCH_EN
  localparam int SX = 2;                     // synchronizer delay seen when SCL is released in phase B
`else
  localparam int SX = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_wbit = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_ready, rsp_valid, rsp_rbit, rsp_err, arb_lost, bus_owned;
  logic       scl_oe, sda_oe, scl_in, sda_in;
  logic       scl_hold = 1'b0;
  logic       sda_hold = 1'b0;

  assign scl_in = ~(scl_oe | scl_hold);
  assign sda_in = ~(sda_oe | sda_hold);

  i2c_bit_master #(.CLK_DIV(CLK_DIV), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_wbit(cmd_wbit),
    .rsp_valid(rsp_valid), .rsp_rbit(rsp_rbit), .rsp_err(rsp_err),
    .arb_lost(arb_lost), .bus_owned(bus_owned),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  int   r_lat, r_first_sda, r_first_scl;
  logic r_rbit, r_err, r_win_hi, r_win_lo, r_stop_ok, r_any_oe;

  // Issue one command at a negedge and follow it cycle by cycle until rsp_valid.
  task automatic run_cmd(input logic [1:0] c, input logic w, input logic hs, input int scl_low);
    logic prev_sda, rise_seen, bad_rise;
    r_lat = -1; r_first_sda = -1; r_first_scl = -1;
    r_rbit = 1'b0; r_err = 1'b0; r_win_hi = 1'b0; r_win_lo = 1'b0; r_any_oe = 1'b0;
    rise_seen = 1'b0; bad_rise = 1'b0; prev_sda = sda_in;
    cmd = c; cmd_wbit = w; sda_hold = hs; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sda_oe && r_first_sda < 0) r_first_sda = k;
      if (scl_oe && r_first_scl < 0) r_first_scl = k;
      if (scl_oe || sda_oe) r_any_oe = 1'b1;
      if (scl_in) begin
        if (sda_in) r_win_hi = 1'b1;
        else        r_win_lo = 1'b1;
      end
      if (sda_in && !prev_sda) begin
        rise_seen = 1'b1;
        if (!scl_in) bad_rise = 1'b1;
      end
      prev_sda = sda_in;
      if (rsp_valid) begin
        r_lat = k; r_rbit = rsp_rbit; r_err = rsp_err;
        break;
      end
      if (scl_low > 0 && k == 3) scl_hold = 1'b1;
      if (scl_low > 0 && k == 4 + scl_low) scl_hold = 1'b0;
      @(negedge clk);
    end
    r_stop_ok = rise_seen && !bad_rise;
    sda_hold = 1'b0;
    scl_hold = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rbit", rsp_rbit, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_arb_lost", arb_lost, 0);
    check("rst_bus_owned", bus_owned, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Data command on an unowned bus is rejected immediately.
    run_cmd(CMD_WRITE, 1'b1, 1'b0, 0);
    check("illegal_lat", r_lat, 0);
    check("illegal_err", r_err, 1);
    check("illegal_lines", r_any_oe, 0);
    check("illegal_owned", bus_owned, 0);

    // START, WRITE 0, WRITE 1, STOP back to back.
    run_cmd(CMD_START, 1'b0, 1'b0, 0);
    check("start_lat", r_lat, LAT);
    check("start_err", r_err, 0);
    check("start_sda_oe_rise", r_first_sda, 8);
    check("start_scl_oe_rise", r_first_scl, 12);
    check("start_rbit", r_rbit, 0);
    check("start_owned", bus_owned, 1);

    run_cmd(CMD_WRITE, 1'b0, 1'b0, 0);
    check("w0_lat", r_lat, LAT + SX);
    check("w0_err", r_err, 0);
    check("w0_sda_low_in_scl_high", r_win_lo, 1);
    check("w0_sda_high_in_scl_high", r_win_hi, 0);

    run_cmd(CMD_WRITE, 1'b1, 1'b0, 0);
    check("w1_lat", r_lat, LAT + SX);
    check("w1_sda_high_in_scl_high", r_win_hi, 1);
    check("w1_sda_low_in_scl_high", r_win_lo, 0);
    check("w1_rbit", r_rbit, 0);

    run_cmd(CMD_STOP, 1'b0, 1'b0, 0);
    check("stop_lat", r_lat, LAT + SX);
    check("stop_err", r_err, 0);
    check("stop_sda_rise_scl_high", r_stop_ok, 1);
    @(negedge clk);
    check("stop_owned", bus_owned, 0);
    check("stop_scl_oe", scl_oe, 0);
    check("stop_sda_oe", sda_oe, 0);

    // READ with the bench holding SDA low, then released; then a repeated START.
    run_cmd(CMD_START, 1'b0, 1'b0, 0);
    check("rs_start_lat", r_lat, LAT);
    run_cmd(CMD_READ, 1'b0, 1'b1, 0);
    check("rd0_lat", r_lat, LAT + SX);
    check("rd0_rbit", r_rbit, 0);
    check("rd0_err", r_err, 0);
    run_cmd(CMD_READ, 1'b0, 1'b0, 0);
    check("rd1_rbit", r_rbit, 1);
    check("rd1_err", r_err, 0);
    run_cmd(CMD_START, 1'b0, 1'b0, 0);
    check("rep_start_lat", r_lat, LAT + SX);
    check("rep_start_scl_low_first", r_first_scl, 0);
    check("rep_start_sda_oe_rise", r_first_sda, 8 + SX);
    check("rep_start_owned", bus_owned, 1);
    run_cmd(CMD_STOP, 1'b0, 1'b0, 0);
    @(negedge clk);

    // WRITE 1 against a competing master holding SDA low.
    run_cmd(CMD_START, 1'b0, 1'b0, 0);
    run_cmd(CMD_WRITE, 1'b1, 1'b1, 0);
    check("arb_lat", r_lat, 8 + SX);
    check("arb_err", r_err, 1);
    @(negedge clk);
    check("arb_lost_set", arb_lost, 1);
    check("arb_owned", bus_owned, 0);
    check("arb_scl_oe", scl_oe, 0);
    check("arb_sda_oe", sda_oe, 0);
    run_cmd(CMD_START, 1'b0, 1'b0, 0);
    check("arb_restart_err", r_err, 0);
    check("arb_restart_cleared", arb_lost, 0);
    check("arb_restart_owned", bus_owned, 1);

    // Reset in the middle of a WRITE 0 (phase B, SDA driven low).
    cmd = CMD_WRITE; cmd_wbit = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_sda_driven", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_scl_oe", scl_oe, 0);
    check("mid_rst_sda_oe", sda_oe, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_owned", bus_owned, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

`ifdef I2C_CLK_STRETCH_EN
    // Slave stretches SCL for 20 cycles in WRITE phase B.
    run_cmd(CMD_START, 1'b0, 1'b0, 0);
    run_cmd(CMD_WRITE, 1'b1, 1'b0, 20);
    check("stretch_lat", r_lat, LAT + 20 + SX);
    check("stretch_err", r_err, 0);
    run_cmd(CMD_STOP, 1'b0, 1'b0, 0);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
